fir_mc_rt: RTL
==============

Name: fir_mc_rt

Overview:
- Multichannel, time-multiplexed transposed-form FIR filter with runtime-reloadable coefficients.
- It generalises the fixed 15-tap single-channel FIR: tap count, channel count and word lengths are all parameters.
- Coefficients are double-buffered (shadow/active), the accumulator carries guard bits, and the output is rounded and saturated.
- It sits in the word-length-optimisation datapath wherever one filter serves several interleaved sample streams.

Parameters:
- N_TAPS, 15, number of taps (≥2).
- N_CH, 2, number of interleaved channels (≥1); CH_W = max(1, clog2(N_CH)).
- COE_INTE_WL / COE_FRAC_WL, 4 / 8, coefficient integer/fraction bits (signed); COE_INTE_WL ≥ 2.
- IN_INTE_WL / IN_FRAC_WL, 4 / 8, input integer/fraction bits (signed).
- OUT_INTE_WL / OUT_FRAC_WL, 4 / 8, output integer/fraction bits (signed); OUT_FRAC_WL ≤ PROD_FRAC_WL.
- PROD_FRAC_WL, 16, fraction bits kept per product; ≤ COE_FRAC_WL+IN_FRAC_WL; low bits truncated (floor).
- ROUND_EN, 1, 1 = round half up at output quantisation, 0 = truncate.
- SAT_EN, 1, 1 = saturate output, 0 = wrap.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- data_in  in  IN_INTE_WL+IN_FRAC_WL  signed sample.
- in_valid  in  1  sample strobe; no backpressure.
- in_ch  in  CH_W  channel index of data_in.
- coe_wr_en  in  1  shadow coefficient write strobe.
- coe_wr_addr  in  clog2(N_TAPS)  tap index.
- coe_wr_data  in  COE_INTE_WL+COE_FRAC_WL  signed coefficient.
- coe_commit  in  1  copy shadow bank to active bank.
- data_out  out  OUT_INTE_WL+OUT_FRAC_WL  signed filtered sample.
- out_valid  out  1  data_out strobe.
- out_ch  out  CH_W  channel of data_out.
- ovf  out  1  one-cycle pulse; output saturated or wrapped.
- ch_err  out  1  one-cycle pulse; in_valid with in_ch ≥ N_CH.

Behaviour:
- Reset values:
  - data_out=0, out_valid=0, out_ch=0, ovf=0, ch_err=0.
  - All channel state registers S[c][k] = 0.
  - Active and shadow banks both hold tap0 = 1.0 and all other taps = 0 (passthrough).
- Products: P[k] = ACT[k]·data_in, full precision, then floor-truncated to PROD_FRAC_WL fraction bits.
- Accumulator: ACC_W = COE_INTE_WL+IN_INTE_WL+clog2(N_TAPS) integer bits plus PROD_FRAC_WL fraction bits. No internal overflow is possible.
- Accepted sample: in_valid=1 and in_ch<N_CH, cycle t, channel c.
  - y = P[0]+S[c][0].
  - S[c][k] <= P[k+1]+S[c][k+1] for k < N_TAPS-2.
  - S[c][N_TAPS-2] <= P[N_TAPS-1].
  - State of other channels is untouched.
- Output registered, latency 1:
  - At edge t+1: out_valid=1, out_ch=c, data_out=Q(y).
  - With no accepted sample: out_valid=0 and data_out holds its previous value.
- Quantisation Q:
  - If ROUND_EN, add 2^-(OUT_FRAC_WL+1) before dropping fraction bits.
  - Then the range check.
    - SAT_EN=1: clamp to [-2^(OUT_INTE_WL-1), 2^(OUT_INTE_WL-1)-2^-OUT_FRAC_WL].
    - SAT_EN=0: keep low bits.
  - ovf pulses with out_valid when the clamp/wrap changed the value.
- Invalid channel: in_valid with in_ch ≥ N_CH is dropped (no state change, out_valid=0); ch_err pulses at t+1.
- Coefficients:
  - coe_wr_en writes SHD[coe_wr_addr]; addresses ≥ N_TAPS are ignored.
  - coe_commit copies SHD→ACT at the clock edge. A coe_wr_en in the same cycle is included in the copy.
  - A sample accepted in the commit cycle uses the old ACT; samples from the next cycle on use the new ACT.
  - Channel state is not cleared on commit.
- Back-to-back samples: one per cycle for any channel order, including the same channel on consecutive cycles.
- Reset mid-operation: everything returns to reset values at the next edge, including active coefficients back to passthrough, and pending output is lost.

Test Plan:
1. Passthrough after reset, Q4.8. ch0 samples 256, -128, 2047 on consecutive cycles -> data_out 256, -128, 2047, one cycle after each; out_ch=0; ovf=0.
2. Impulse response.
   - Write h=[0.25, 0.5, 0.25] (64, 128, 64) to taps 0..2, taps 3..14 = 0, then commit.
   - ch0 sample 256, then zeros -> outputs 64, 128, 64, 0, 0.
3. Channel isolation (N_CH=2). Interleave ch0 impulse 256 with ch1 constant 0 using the coefficients from scenario 2 -> ch1 outputs all 0; ch0 outputs 64, 128, 64 on its own samples.
4. Saturation. All 15 taps = 1.0, ch0 constant 2047 -> data_out clamps at 2047 once the running sum exceeds it, with ovf=1. Negative input -2048 -> clamps at -2048.
5. Commit timing.
   - With coefficients from scenario 2, write tap0 = 0.5 and assert commit in the same cycle as a ch0 sample 256 -> that output is 64.
   - The next ch0 sample 256 -> output 128+128 = 256 (new tap0 plus stored state).
6. Error and reset. in_ch=3 with N_CH=2 -> ch_err pulse, no out_valid. Assert rst mid-stream -> outputs 0; the next sample 256 outputs 256 (passthrough restored).

Source files
------------

// File: rtl/fir_mc_rt.sv
// Multichannel time-multiplexed transposed-form FIR with double-buffered runtime coefficients.
// One sample per cycle from any channel; output is rounded/saturated and registered (latency 1).
module fir_mc_rt_tap #(
  parameter int CW = 12,
  parameter int IW = 12,
  parameter int SH = 0,
  parameter int AW = 28
) (
  input  logic signed [CW-1:0] coe,
  input  logic signed [IW-1:0] x,
  output logic signed [AW-1:0] p
);
  logic signed [CW+IW-1:0] full;
  assign full = coe * x;
  assign p    = AW'(full >>> SH);
endmodule

module fir_mc_rt #(
  parameter int N_TAPS       = 15,
  parameter int N_CH         = 2,
  parameter int COE_INTE_WL  = 4,
  parameter int COE_FRAC_WL  = 8,
  parameter int IN_INTE_WL   = 4,
  parameter int IN_FRAC_WL   = 8,
  parameter int OUT_INTE_WL  = 4,
  parameter int OUT_FRAC_WL  = 8,
  parameter int PROD_FRAC_WL = 16,
  parameter int ROUND_EN     = 1,
  parameter int SAT_EN       = 1,
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int AW    = $clog2(N_TAPS),
  localparam int IN_W  = IN_INTE_WL + IN_FRAC_WL,
  localparam int COE_W = COE_INTE_WL + COE_FRAC_WL,
  localparam int OUT_W = OUT_INTE_WL + OUT_FRAC_WL
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [IN_W-1:0]  data_in,
  input  logic                    in_valid,
  input  logic [CH_W-1:0]         in_ch,
  input  logic                    coe_wr_en,
  input  logic [AW-1:0]           coe_wr_addr,
  input  logic signed [COE_W-1:0] coe_wr_data,
  input  logic                    coe_commit,
  output logic signed [OUT_W-1:0] data_out,
  output logic                    out_valid,
  output logic [CH_W-1:0]         out_ch,
  output logic                    ovf,
  output logic                    ch_err
);
  localparam int SH    = COE_FRAC_WL + IN_FRAC_WL - PROD_FRAC_WL;
  localparam int ACC_W = COE_INTE_WL + IN_INTE_WL + $clog2(N_TAPS) + PROD_FRAC_WL;
  localparam int DROP  = PROD_FRAC_WL - OUT_FRAC_WL;
  localparam int RW    = ACC_W + 1;
  localparam logic signed [COE_W-1:0] ONE  = COE_W'(1 << COE_FRAC_WL);
  localparam logic signed [RW-1:0]    RND  = (ROUND_EN != 0 && DROP > 0) ?
                                             (RW'(1) <<< ((DROP > 0) ? DROP - 1 : 0)) : '0;
  localparam logic signed [RW-1:0]    QMAX = RW'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [RW-1:0]    QMIN = ~QMAX;

  logic signed [COE_W-1:0] act    [N_TAPS];
  logic signed [COE_W-1:0] shd    [N_TAPS];
  logic signed [COE_W-1:0] shd_nx [N_TAPS];
  logic signed [ACC_W-1:0] prod   [N_TAPS];
  logic signed [ACC_W-1:0] st     [N_CH][N_TAPS-1];
  logic signed [ACC_W-1:0] st_nx  [N_TAPS-1];
  logic signed [ACC_W-1:0] y;
  logic signed [RW-1:0]    y_r, y_q;
  logic signed [OUT_W-1:0] q;
  logic                    ch_ok, accept, hi, lo;
  logic [CH_W-1:0]         ci;

  if ((1 << CH_W) == N_CH) begin : g_ch_full
    assign ch_ok = 1'b1;
  end else begin : g_ch_part
    assign ch_ok = (int'(in_ch) < N_CH);
  end

  assign accept = in_valid && ch_ok;
  assign ci     = accept ? in_ch : '0;

  for (genvar k = 0; k < N_TAPS; k++) begin : g_tap
    fir_mc_rt_tap #(.CW(COE_W), .IW(IN_W), .SH(SH), .AW(ACC_W)) u_tap (
      .coe (act[k]),
      .x   (data_in),
      .p   (prod[k])
    );
  end

  // A write in the commit cycle must land in the copied bank, so commit takes shd_nx.
  always_comb begin
    for (int k = 0; k < N_TAPS; k++) shd_nx[k] = shd[k];
    if (coe_wr_en && (int'(coe_wr_addr) < N_TAPS)) shd_nx[coe_wr_addr] = coe_wr_data;
  end

  always_comb begin
    y = prod[0] + st[ci][0];
    for (int k = 0; k < N_TAPS - 2; k++) st_nx[k] = prod[k+1] + st[ci][k+1];
    st_nx[N_TAPS-2] = prod[N_TAPS-1];
  end

  // One extra bit keeps the rounding add from wrapping near full scale.
  always_comb begin
    y_r = RW'(y) + RND;
    y_q = y_r >>> DROP;
    hi  = y_q > QMAX;
    lo  = y_q < QMIN;
    q   = y_q[OUT_W-1:0];
    if (SAT_EN != 0) begin
      if (hi)      q = QMAX[OUT_W-1:0];
      else if (lo) q = QMIN[OUT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out  <= '0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      ovf       <= 1'b0;
      ch_err    <= 1'b0;
      for (int k = 0; k < N_TAPS; k++) begin
        act[k] <= (k == 0) ? ONE : '0;
        shd[k] <= (k == 0) ? ONE : '0;
      end
      for (int c = 0; c < N_CH; c++)
        for (int k = 0; k < N_TAPS - 1; k++) st[c][k] <= '0;
    end else begin
      out_valid <= accept;
      ovf       <= accept && (hi || lo);
      ch_err    <= in_valid && !ch_ok;
      for (int k = 0; k < N_TAPS; k++) begin
        shd[k] <= shd_nx[k];
        if (coe_commit) act[k] <= shd_nx[k];
      end
      if (accept) begin
        data_out <= q;
        out_ch   <= in_ch;
        for (int k = 0; k < N_TAPS - 1; k++) st[ci][k] <= st_nx[k];
      end
    end
  end
endmodule
